// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, PC step and the canonical NOP.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } if_state_e;

  localparam int PC_INC = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage driving an external synchronous ROM (1-cycle read latency).
//   state | meaning
//   BOOT  | first cycle after reset, no request issued
//   RUN   | fetching; stall holds, redirect re-steers
//   FAULT | misaligned redirect seen; dead until reset
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] rom_addr,
  output logic            rom_en,
  input  logic [XLEN-1:0] rom_dout,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            fault
);

  if_state_e       state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] resp_pc, resp_pc_nxt;
  logic            resp_valid, resp_valid_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BOOT;
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      resp_pc    <= resp_pc_nxt;
      resp_valid <= resp_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    resp_pc_nxt    = resp_pc;
    resp_valid_nxt = resp_valid;
    rom_en         = 1'b0;
    rom_addr       = fetch_pc;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        // Redirect bypasses straight to the ROM so the target lands one cycle later,
        // overwriting the in-flight word; it also outranks stall.
        if (redirect_valid) begin
          if (is_misaligned(redirect_pc[1:0])) begin
            state_nxt      = ST_FAULT;
            resp_valid_nxt = 1'b0;
          end else begin
            rom_en         = 1'b1;
            rom_addr       = redirect_pc;
            fetch_pc_nxt   = redirect_pc + XLEN'(PC_INC);
            resp_pc_nxt    = redirect_pc;
            resp_valid_nxt = 1'b1;
          end
        end else if (!stall) begin
          rom_en         = 1'b1;
          fetch_pc_nxt   = fetch_pc + XLEN'(PC_INC);
          resp_pc_nxt    = fetch_pc;
          resp_valid_nxt = 1'b1;
        end
      end
      default: resp_valid_nxt = 1'b0;
    endcase
  end

  assign if_valid = resp_valid && (state == ST_RUN);
  assign if_pc    = resp_pc;
  assign if_instr = rom_dout;
  assign fault    = (state == ST_FAULT);

endmodule
